// File: rtl/stack_arb_pkg.sv
// Shared types and helpers for the stack arbiter: lock state, op encoding,
// and occupancy counter sizing.
package stack_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  localparam logic OP_POP  = 1'b0;
  localparam logic OP_PUSH = 1'b1;

  // Width needed to count 0..depth inclusive.
  function automatic int depth_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request after
// the pointer position, wrapping around, and returns it one-hot and encoded.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one hardware stack between NUM_REQ requesters: round-robin grant,
// optional lock for atomic sequences, depth tracking with overflow/underflow guard.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 32,
  parameter int LOCK_TIMEOUT = 16,
  localparam int DW          = depth_width(DEPTH),
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW          = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_push,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          stk_push,
  output logic                          stk_pop,
  output logic [DATA_WIDTH-1:0]         stk_value,
  input  logic [DATA_WIDTH-1:0]         stk_output,
  output logic [DW-1:0]                 depth,
  output logic                          full,
  output logic                          empty,
  output logic                          err_overflow,
  output logic                          err_underflow,
  output logic                          err_lock_timeout
);

  // Handshake: requester i transfers one op in the cycle where
  // req_valid[i] & req_ready[i]; ready never depends on the request's own
  // op/lock/data, only on who is eligible, and at most one ready bit is set.

  lock_state_t              state_q, state_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         rr_q;
  logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0]            depth_q, depth_d;
  logic [IDX_W-1:0]         iss_idx;

  logic [NUM_REQ-1:0]       owner_mask;
  logic [NUM_REQ-1:0]       eligible;
  logic [NUM_REQ-1:0]       grant;
  logic [IDX_W-1:0]         win_idx;
  logic                     grant_valid;
  logic                     hs;
  logic                     win_push;
  logic                     win_lock;
  logic [DATA_WIDTH-1:0]    win_data;
  logic                     owner_valid;
  logic                     timeout_hit;
  logic                     is_full;
  logic                     is_empty;
  logic                     do_push, do_pop, do_ovf, do_unf;

  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign eligible   = (state_q == ST_LOCKED) ? (req_valid & owner_mask) : req_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (eligible),
    .ptr         (rr_q),
    .grant       (grant),
    .grant_idx   (win_idx),
    .grant_valid (grant_valid)
  );

  // No grants while reset is asserted so nothing is lost in the reset cycle.
  assign req_ready = rst ? grant : '0;
  assign hs        = rst & grant_valid;
  assign win_push  = req_push[win_idx];
  assign win_lock  = req_lock[win_idx];
  assign win_data  = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];

  assign owner_valid      = req_valid[owner_q];
  assign timeout_hit      = (state_q == ST_LOCKED) && !owner_valid &&
                            (tmo_cnt_q == TW'(LOCK_TIMEOUT - 1));
  assign err_lock_timeout = rst & timeout_hit;

  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);
  assign depth    = depth_q;
  assign full     = is_full;
  assign empty    = is_empty;

  assign do_push = hs && (win_push == OP_PUSH) && !is_full;
  assign do_ovf  = hs && (win_push == OP_PUSH) &&  is_full;
  assign do_pop  = hs && (win_push == OP_POP)  && !is_empty;
  assign do_unf  = hs && (win_push == OP_POP)  &&  is_empty;
  assign depth_d = depth_q + DW'(do_push) - DW'(do_pop);

  // Lock FSM: an accepted op decides the next state from its lock bit;
  // otherwise a locked owner that stays idle long enough is evicted.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    tmo_cnt_d = tmo_cnt_q;
    if (hs) begin
      owner_d   = win_idx;
      tmo_cnt_d = '0;
      state_d   = win_lock ? ST_LOCKED : ST_IDLE;
    end else if (state_q == ST_LOCKED) begin
      if (timeout_hit) begin
        state_d   = ST_IDLE;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_q          <= IDX_W'(NUM_REQ - 1);
      tmo_cnt_q     <= '0;
      depth_q       <= '0;
      iss_idx       <= '0;
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      stk_value     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      tmo_cnt_q     <= tmo_cnt_d;
      depth_q       <= depth_d;
      if (hs) begin
        rr_q <= win_idx;
      end
      iss_idx       <= win_idx;
      stk_push      <= do_push;
      stk_pop       <= do_pop;
      stk_value     <= do_push ? win_data : '0;
      err_overflow  <= do_ovf;
      err_underflow <= do_unf;
      // Stack output is valid while stk_pop is high; an underflow answers with zero.
      rsp_valid     <= (stk_pop || err_underflow) ? (NUM_REQ'(1) << iss_idx) : '0;
      rsp_data      <= stk_pop ? stk_output : '0;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_stack_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int DATA_WIDTH   = 8;
  localparam int DEPTH        = 32;
  localparam int LOCK_TIMEOUT = 16;
  localparam int DW           = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_push = '0;
  logic [NUM_REQ-1:0]     req_lock = '0;
  logic [2*DATA_WIDTH-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [DATA_WIDTH-1:0]  rsp_data;
  logic                   stk_push;
  logic                   stk_pop;
  logic [DATA_WIDTH-1:0]  stk_value;
  logic [DATA_WIDTH-1:0]  stk_output;
  logic [DW-1:0]          depth;
  logic                   full;
  logic                   empty;
  logic                   err_overflow;
  logic                   err_underflow;
  logic                   err_lock_timeout;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  stack_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_push(req_push), .req_lock(req_lock), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_value(stk_value), .stk_output(stk_output),
    .depth(depth), .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_lock_timeout(err_lock_timeout)
  );

  // Behavioural stack RAM, no bounds checking, like the real one.
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  int sp = 0;
  always @(posedge clk) begin
    if (!rst) sp <= 0;
    else if (stk_push) begin
      ram[sp % DEPTH] <= stk_value;
      sp <= (sp + 1) % DEPTH;
    end else if (stk_pop) sp <= (sp + DEPTH - 1) % DEPTH;
  end
  always_comb stk_output = ram[(sp + DEPTH - 1) % DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_WIDTH-1:0] exp_q[$];
  int   m_rr = NUM_REQ - 1;
  int   m_lock = -1;
  int   m_idle = 0;
  logic e1_push = 0, e1_pop = 0, e1_ovf = 0, e1_unf = 0;
  logic [DATA_WIDTH-1:0] e1_val = 0, e1_data = 0;
  int   e1_idx = 0;
  logic [NUM_REQ-1:0] e2_mask = 0;
  logic [DATA_WIDTH-1:0] e2_data = 0;
  bit   seen_reset = 0;

  logic [DATA_WIDTH-1:0] rsp_log[$];
  int   rsp_idx_log[$];
  int   grant_log[$];
  logic [NUM_REQ-1:0] ready_trace[$];
  logic to_trace[$];
  int   push_cnt = 0, pop_cnt = 0, ovf_cnt = 0, unf_cnt = 0, to_cnt = 0;

  always @(negedge clk) begin : model
    logic [NUM_REQ-1:0] exp_ready;
    logic exp_to;
    int win;
    exp_ready = '0;
    exp_to    = 1'b0;
    win       = -1;
    if (rst) begin
      if (m_lock >= 0) begin
        if (req_valid[m_lock]) win = m_lock;
        else exp_to = (m_idle == LOCK_TIMEOUT - 1);
      end else begin
        for (int k = 1; k <= NUM_REQ; k++)
          if (win < 0 && req_valid[(m_rr + k) % NUM_REQ]) win = (m_rr + k) % NUM_REQ;
      end
      if (win >= 0) exp_ready[win] = 1'b1;
    end

    if (seen_reset) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("err_lock_timeout", 32'(err_lock_timeout), 32'(exp_to));
      chk("stk_push", 32'(stk_push), 32'(e1_push));
      chk("stk_pop", 32'(stk_pop), 32'(e1_pop));
      if (e1_push) chk("stk_value", 32'(stk_value), 32'(e1_val));
      chk("err_overflow", 32'(err_overflow), 32'(e1_ovf));
      chk("err_underflow", 32'(err_underflow), 32'(e1_unf));
      chk("rsp_valid", 32'(rsp_valid), 32'(e2_mask));
      if (e2_mask != 0) chk("rsp_data", 32'(rsp_data), 32'(e2_data));
      chk("depth", 32'(depth), 32'(exp_q.size()));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));

      if (rsp_valid != 0) begin
        rsp_log.push_back(rsp_data);
        rsp_idx_log.push_back(rsp_valid[1] ? 1 : 0);
      end
      if (req_ready != 0) grant_log.push_back(req_ready[1] ? 1 : 0);
      ready_trace.push_back(req_ready);
      to_trace.push_back(err_lock_timeout);
      push_cnt += int'(stk_push);
      pop_cnt  += int'(stk_pop);
      ovf_cnt  += int'(err_overflow);
      unf_cnt  += int'(err_underflow);
      to_cnt   += int'(err_lock_timeout);
    end

    if (!rst) begin
      seen_reset = 1;
      exp_q.delete();
      m_rr = NUM_REQ - 1; m_lock = -1; m_idle = 0;
      e1_push = 0; e1_pop = 0; e1_ovf = 0; e1_unf = 0; e1_val = 0; e1_data = 0; e1_idx = 0;
      e2_mask = '0; e2_data = '0;
    end else begin
      e2_mask = '0;
      if (e1_pop || e1_unf) e2_mask[e1_idx] = 1'b1;
      e2_data = e1_pop ? e1_data : '0;
      e1_push = 0; e1_pop = 0; e1_ovf = 0; e1_unf = 0;
      if (win >= 0) begin
        e1_idx = win;
        if (req_push[win]) begin
          if (exp_q.size() < DEPTH) begin
            e1_val = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
            exp_q.push_back(e1_val);
            e1_push = 1;
          end else e1_ovf = 1;
        end else begin
          if (exp_q.size() > 0) begin
            e1_data = exp_q.pop_back();
            e1_pop = 1;
          end else e1_unf = 1;
        end
        m_rr = win;
        m_lock = req_lock[win] ? win : -1;
        m_idle = 0;
      end else if (m_lock >= 0) begin
        if (exp_to) begin m_lock = -1; m_idle = 0; end
        else m_idle++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [1:0] v, input logic [1:0] p, input logic [1:0] l,
                      input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v; req_push = p; req_lock = l; req_wdata = {d1, d0};
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic clear_logs();
    rsp_log.delete(); rsp_idx_log.delete(); grant_log.delete();
    ready_trace.delete(); to_trace.delete();
    push_cnt = 0; pop_cnt = 0; ovf_cnt = 0; unf_cnt = 0; to_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int gseq, iseq, nz;
    rst = 1'b0;
    idle(2);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_depth", 32'(depth), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;

    // push 0x11, 0x22 then pop twice: LIFO order back
    clear_logs();
    step(2'b01, 2'b01, 2'b00, 8'h11, 8'h00);
    step(2'b01, 2'b01, 2'b00, 8'h22, 8'h00);
    step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    idle(3);
    chk("t1_push_cnt", 32'(push_cnt), 32'd2);
    chk("t1_rsp_cnt", 32'(rsp_log.size()), 32'd2);
    chk("t1_rsp0", 32'(rsp_log[0]), 32'h22);
    chk("t1_rsp1", 32'(rsp_log[1]), 32'h11);
    chk("t1_depth", 32'(depth), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);

    // req1 fills six words, then both requesters pop together
    for (int i = 0; i < 6; i++) step(2'b10, 2'b10, 2'b00, 8'h00, 8'(8'h40 + i));
    idle(1);
    clear_logs();
    for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 2'b00, 8'h00, 8'h00);
    idle(3);
    gseq = 0; iseq = 0;
    for (int i = 0; i < grant_log.size() && i < 8; i++) gseq |= grant_log[i] << i;
    for (int i = 0; i < rsp_idx_log.size() && i < 8; i++) iseq |= rsp_idx_log[i] << i;
    chk("t2_grant_cnt", 32'(grant_log.size()), 32'd4);
    chk("t2_grant_seq", 32'(gseq), 32'hA);
    chk("t2_rsp_seq", 32'(iseq), 32'hA);
    chk("t2_rsp_first", 32'(rsp_log[0]), 32'h45);
    chk("t2_rsp_last", 32'(rsp_log[3]), 32'h42);
    step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    idle(3);
    chk("t2_drained", 32'(depth), 32'd0);

    // fill to DEPTH, one extra push overflows, then pop straight away
    clear_logs();
    for (int i = 0; i < DEPTH; i++) step(2'b01, 2'b01, 2'b00, 8'(i), 8'h00);
    step(2'b01, 2'b01, 2'b00, 8'hAA, 8'h00);
    chk("t3_depth_full", 32'(depth), 32'd32);
    chk("t3_full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    idle(3);
    chk("t3_push_cnt", 32'(push_cnt), 32'd32);
    chk("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
    chk("t3_rsp_cnt", 32'(rsp_log.size()), 32'd32);
    chk("t3_rsp_first", 32'(rsp_log[0]), 32'h1F);
    chk("t3_rsp_last", 32'(rsp_log[31]), 32'h00);

    // pop at empty
    clear_logs();
    step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    idle(3);
    chk("t4_unf_cnt", 32'(unf_cnt), 32'd1);
    chk("t4_pop_cnt", 32'(pop_cnt), 32'd0);
    chk("t4_rsp_cnt", 32'(rsp_log.size()), 32'd1);
    chk("t4_rsp_data", 32'(rsp_log[0]), 32'h00);
    chk("t4_depth", 32'(depth), 32'd0);

    // req1 takes the lock then goes quiet; req0 waits for the timeout
    step(2'b10, 2'b10, 2'b10, 8'h00, 8'h55);
    clear_logs();
    for (int i = 0; i < 18; i++) step(2'b01, 2'b01, 2'b00, 8'h66, 8'h00);
    idle(2);
    nz = 0;
    for (int i = 0; i < 16 && i < ready_trace.size(); i++) if (ready_trace[i] != 0) nz++;
    chk("t5_blocked", 32'(nz), 32'd0);
    chk("t5_to_cnt", 32'(to_cnt), 32'd1);
    chk("t5_to_cycle", 32'(to_trace[15]), 32'd1);
    chk("t5_first_grant", 32'(ready_trace[16]), 32'h1);
    chk("t5_depth", 32'(depth), 32'd3);

    // reset during back-to-back pops
    clear_logs();
    step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    rst = 1'b0;
    step(2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
    rst = 1'b1;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_stk_pop", 32'(stk_pop), 32'd0);
    chk("t6_depth", 32'(depth), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    idle(3);
    chk("t6_rsp_cnt", 32'(rsp_log.size()), 32'd1);
    chk("t6_rsp_data", 32'(rsp_log[0]), 32'h66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
